// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one xALU between two requesters
//
// Purpose: grants one of two requesters (0 = keypad/calculator, 1 = PicoVersat)
// round-robin, rejects illegal opcodes and divide-by-zero without touching the
// ALU, issues a one-cycle command to xALU, waits for alu_done under a timeout
// and returns a registered result with a one-cycle response pulse.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid0/1, req_ready0/1    request handshake (transfer on valid & ready)
//   req_a0/1, req_b0/1, req_op0/1 operands and opcode (0001 add, 0010 mul, 0100 div)
//   rsp_valid0/1                  one-cycle response pulse to the granted requester
//   rsp_result, rsp_err           result / error of the last completed request
//   alu_sel, alu_wr               xALU command strobe (one cycle)
//   alu_a, alu_b, alu_op          xALU operands and operation
//   alu_result, alu_done          xALU result and completion
//   busy, grant_id                status: not idle / requester being served
module alu_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid0,
  input  logic       req_valid1,
  output logic       req_ready0,
  output logic       req_ready1,
  input  logic [3:0] req_a0,
  input  logic [3:0] req_a1,
  input  logic [3:0] req_b0,
  input  logic [3:0] req_b1,
  input  logic [3:0] req_op0,
  input  logic [3:0] req_op1,
  output logic       rsp_valid0,
  output logic       rsp_valid1,
  output logic [7:0] rsp_result,
  output logic       rsp_err,
  output logic       alu_sel,
  output logic       alu_wr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_done,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_id_q, grant_id_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       result_q, result_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick0, pick1;
  logic [3:0]       in_a, in_b, in_op;
  logic             legal;

  // Requester 0 wins when it is alone or when requester 1 was served last.
  assign pick0 = req_valid0 && (!req_valid1 || last_grant_q);
  assign pick1 = req_valid1 && !pick0;

  assign req_ready0 = (state_q == S_IDLE) && pick0;
  assign req_ready1 = (state_q == S_IDLE) && pick1;

  assign in_a  = pick1 ? req_a1  : req_a0;
  assign in_b  = pick1 ? req_b1  : req_b0;
  assign in_op = pick1 ? req_op1 : req_op0;

  assign legal = (in_op == 4'b0001) || (in_op == 4'b0010) ||
                 ((in_op == 4'b0100) && (in_b != 4'd0));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    err_d        = err_q;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (pick0 || pick1) begin
          a_d          = in_a;
          b_d          = in_b;
          op_d         = in_op;
          grant_id_d   = pick1;
          last_grant_d = pick1;
          if (legal) begin
            state_d = S_ISSUE;
          end else begin
            result_d = 8'h00;
            err_d    = 1'b1;
            state_d  = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // cnt_q == 0 marks the first WAIT cycle, where a done left over from
        // a previous operation may still be asserted.
        if (alu_done && (cnt_q != '0)) begin
          result_d = alu_result;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          result_d = 8'hFF;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      op_q         <= 4'd0;
      result_q     <= 8'h00;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign alu_sel    = (state_q == S_ISSUE);
  assign alu_wr     = (state_q == S_ISSUE);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_valid0 = (state_q == S_RESP) && !grant_id_q;
  assign rsp_valid1 = (state_q == S_RESP) && grant_id_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic       req_ready0, req_ready1;
  logic [3:0] req_a0 = 4'd0, req_a1 = 4'd0, req_b0 = 4'd0, req_b1 = 4'd0;
  logic [3:0] req_op0 = 4'd0, req_op1 = 4'd0;
  logic       rsp_valid0, rsp_valid1;
  logic [7:0] rsp_result;
  logic       rsp_err;
  logic       alu_sel, alu_wr;
  logic [3:0] alu_a, alu_b, alu_op;
  logic [7:0] alu_result;
  logic       alu_done;
  logic       busy, grant_id;

  int checks = 0;
  int errors = 0;

  // ALU model: done pulses alu_delay cycles after the sel edge (0 = never)
  int         alu_delay = 4;
  int         m_cnt = 0;
  logic       m_done = 1'b0;
  logic [7:0] m_res = 8'h00;
  logic       stale = 1'b0;

  int sel_cnt = 0, both_rdy = 0, rsp0_cnt = 0;

  alu_arbiter #(.TIMEOUT(16), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_sel(alu_sel), .alu_wr(alu_wr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_done(alu_done),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (alu_sel) begin
      m_cnt  <= alu_delay;
      m_done <= 1'b0;
      case (alu_op)
        4'b0001: m_res <= {4'd0, alu_a} + {4'd0, alu_b};
        4'b0010: m_res <= {4'd0, alu_a} * {4'd0, alu_b};
        4'b0100: m_res <= (alu_b != 4'd0) ? {4'd0, alu_a} / {4'd0, alu_b} : 8'hEE;
        default: m_res <= 8'hEE;
      endcase
    end else if (m_cnt == 1) begin
      m_done <= 1'b1;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 1) m_cnt <= m_cnt - 1;
    end
  end

  assign alu_done   = m_done | stale;
  assign alu_result = m_done ? m_res : 8'hAA;

  always @(negedge clk) begin
    if (alu_sel) sel_cnt++;
    if (req_ready0 && req_ready1) both_rdy++;
    if (rsp_valid0) rsp0_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    if (id == 0) begin
      req_a0 = a; req_b0 = b; req_op0 = op; req_valid0 = 1'b1;
    end else begin
      req_a1 = a; req_b1 = b; req_op1 = op; req_valid1 = 1'b1;
    end
    #1;
  endtask

  // Waits for ready, lets the transfer edge pass, drops valid; returns in cycle T+1.
  task automatic accept(input int id, input string tag);
    int n;
    n = 0;
    while (!((id == 0) ? req_ready0 : req_ready1) && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_accept"}, 32'(n < 60), 32'd1);
    tick();
    if (id == 0) req_valid0 = 1'b0;
    else         req_valid1 = 1'b0;
  endtask

  task automatic wait_rsp(input int id, input int maxc, input string tag, output int n);
    n = 0;
    while (!((id == 0) ? rsp_valid0 : rsp_valid1) && n < maxc) begin
      tick();
      n++;
    end
    chk({tag, "_rsp_seen"}, 32'((id == 0) ? rsp_valid0 : rsp_valid1), 32'd1);
  endtask

  initial begin
    int n;

    // reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_sel", alu_sel, 0);
    chk("rst_wr", alu_wr, 0);
    chk("rst_result", rsp_result, 8'h00);
    chk("rst_err", rsp_err, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_rsp", {rsp_valid1, rsp_valid0}, 0);
    chk("rst_aluop", {alu_a, alu_b, alu_op}, 0);
    rst = 1'b0;
    tick();

    // req0 add 3+5
    sel_cnt = 0; alu_delay = 4;
    send(0, 4'd3, 4'd5, 4'b0001);
    accept(0, "add");
    chk("add_sel", alu_sel, 1);
    chk("add_wr", alu_wr, 1);
    chk("add_op", alu_op, 4'b0001);
    chk("add_ab", {alu_a, alu_b}, 8'h35);
    chk("add_busy", busy, 1);
    tick();
    chk("add_sel_off", alu_sel, 0);
    chk("add_hold", {alu_a, alu_b, alu_op}, 12'h351);
    wait_rsp(0, 30, "add", n);
    chk("add_latency", n, 5);
    chk("add_result", rsp_result, 8'h08);
    chk("add_err", rsp_err, 0);
    chk("add_rsp1", rsp_valid1, 0);
    chk("add_selcnt", sel_cnt, 1);
    tick();
    chk("add_pulse", rsp_valid0, 0);
    chk("add_idle", busy, 0);

    // req1 div by zero: rejected, answered the cycle after accept
    sel_cnt = 0;
    send(1, 4'd7, 4'd0, 4'b0100);
    accept(1, "dz");
    chk("dz_rsp1", rsp_valid1, 1);
    chk("dz_rsp0", rsp_valid0, 0);
    chk("dz_err", rsp_err, 1);
    chk("dz_result", rsp_result, 8'h00);
    chk("dz_grant", grant_id, 1);
    tick(); tick();
    chk("dz_selcnt", sel_cnt, 0);

    // both valid together: last grant was 1, so req0 goes first
    both_rdy = 0; alu_delay = 3;
    send(0, 4'd3, 4'd4, 4'b0010);
    send(1, 4'd9, 4'd2, 4'b0100);
    chk("both_rdy0", req_ready0, 1);
    chk("both_rdy1", req_ready1, 0);
    accept(0, "both0");
    wait_rsp(0, 30, "both0", n);
    chk("both0_result", rsp_result, 8'h0C);
    chk("both0_err", rsp_err, 0);
    accept(1, "both1");
    wait_rsp(1, 30, "both1", n);
    chk("both1_result", rsp_result, 8'h04);
    chk("both1_err", rsp_err, 0);
    chk("both_never_two_ready", both_rdy, 0);

    // req0 illegal opcode
    sel_cnt = 0;
    send(0, 4'd2, 4'd2, 4'b0011);
    accept(0, "badop");
    chk("badop_rsp0", rsp_valid0, 1);
    chk("badop_err", rsp_err, 1);
    chk("badop_result", rsp_result, 8'h00);
    tick(); tick();
    chk("badop_selcnt", sel_cnt, 0);

    // timeout: ALU never finishes
    alu_delay = 0;
    send(0, 4'd2, 4'd2, 4'b0001);
    accept(0, "tmo");
    wait_rsp(0, 40, "tmo", n);
    chk("tmo_latency", n, 17);
    chk("tmo_result", rsp_result, 8'hFF);
    chk("tmo_err", rsp_err, 1);
    alu_delay = 4;
    send(1, 4'd1, 4'd2, 4'b0001);
    accept(1, "after_tmo");
    wait_rsp(1, 30, "after_tmo", n);
    chk("after_tmo_result", rsp_result, 8'h03);
    chk("after_tmo_err", rsp_err, 0);

    // reset during WAIT
    send(0, 4'd2, 4'd3, 4'b0010);
    accept(0, "rstw");
    tick(); tick();
    chk("rstw_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    rsp0_cnt = 0;
    chk("rstw_busy", busy, 0);
    chk("rstw_result", rsp_result, 8'h00);
    chk("rstw_alu", {alu_sel, alu_wr, alu_a, alu_b, alu_op}, 0);
    chk("rstw_rsp", {rsp_valid1, rsp_valid0, rsp_err, grant_id}, 0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("rstw_no_rsp", rsp0_cnt, 0);
    send(0, 4'd1, 4'd1, 4'b0001);
    accept(0, "rstw_fresh");
    wait_rsp(0, 30, "rstw_fresh", n);
    chk("rstw_fresh_result", rsp_result, 8'h02);
    chk("rstw_fresh_err", rsp_err, 0);

    // stale done in first WAIT cycle is ignored; real done two cycles later
    alu_delay = 2;
    send(0, 4'd4, 4'd5, 4'b0001);
    accept(0, "stale");
    tick();
    stale = 1'b1;
    tick();
    stale = 1'b0;
    chk("stale_no_rsp_t3", rsp_valid0, 0);
    tick();
    chk("stale_no_rsp_t4", rsp_valid0, 0);
    tick();
    chk("stale_rsp_t5", rsp_valid0, 1);
    chk("stale_result", rsp_result, 8'h09);
    chk("stale_err", rsp_err, 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one xALU instance between two requesters: requester 0 is the keypad/calculator front-end, requester 1 is the PicoVersat port.
- Arbitrates round-robin and screens out illegal requests.
- Issues a one-cycle command to the ALU, waits for `alu_done` under a timeout, and returns a registered result with a one-cycle response pulse.
- Sits between the requesters and xALU; it is the only driver of the xALU command inputs.

Parameters:
- TIMEOUT, 64, maximum WAIT cycles before the request is aborted with an error.
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid0 / req_valid1  in  1  request pending (held until accepted)
- req_ready0 / req_ready1  out  1  accept strobe; transfer occurs when valid & ready
- req_a0 / req_a1  in  4  first operand
- req_b0 / req_b1  in  4  second operand
- req_op0 / req_op1  in  4  opcode: 0001 add, 0010 mul, 0100 div
- rsp_valid0 / rsp_valid1  out  1  one-cycle response pulse
- rsp_result  out  8  result of the last completed request
- rsp_err  out  1  error flag, qualified by rsp_validN
- alu_sel  out  1  to xALU alu_sel
- alu_wr  out  1  to xALU wr_enable
- alu_a / alu_b  out  4  to xALU first_nr / second_nr
- alu_op  out  4  to xALU operation
- alu_result  in  8  from xALU result_uncoded
- alu_done  in  1  from xALU alu_done
- busy  out  1  high in every state except IDLE
- grant_id  out  1  requester currently being served (last served when idle)

Behaviour:
- Reset (async) values:
  - state = IDLE; last_grant = 1, so requester 0 wins first.
  - All outputs = 0: alu_sel, alu_wr, alu_a, alu_b, alu_op, rsp_result, rsp_err, rsp_validN, busy, grant_id. Counter = 0.
  - Reset mid-operation aborts with no response; the ALU is left to finish and its done is ignored.
- IDLE:
  - req_readyN is combinational and only ever high in IDLE.
  - Only valid: grant it. Both valid: grant the requester != last_grant.
  - At most one ready high per cycle.
  - On accept: latch a, b, op; set grant_id and last_grant.
  - Legal request (op in {0001, 0010, 0100} and not (op=0100 and b=0)) -> ISSUE.
  - Otherwise -> RESP with err=1, result=00h; the ALU is never touched.
- ISSUE (1 cycle):
  - alu_sel = alu_wr = 1.
  - alu_a, alu_b, alu_op = latched values; they are held stable from ISSUE through WAIT.
  - Next state WAIT; counter cleared.
- WAIT:
  - alu_sel = alu_wr = 0; counter increments each cycle.
  - alu_done is ignored in the first WAIT cycle (stale-done blanking).
  - From the 2nd WAIT cycle, alu_done=1 -> capture alu_result into rsp_result, err=0, go to RESP.
  - If the counter reaches TIMEOUT with no done -> rsp_result = FFh, err=1, go to RESP.
  - If done and timeout coincide, done wins.
- RESP (1 cycle):
  - rsp_valid of the granted requester = 1; the other stays 0.
  - Next state IDLE.
  - rsp_result and rsp_err hold until the next RESP.
- Latency:
  - Accept at cycle T; alu_sel at T+1; earliest done accepted at T+3; rsp_valid one cycle after done is sampled.
  - An illegal request gives rsp_valid at T+1.
  - New accept earliest the cycle after RESP.
- Requests arriving while busy wait, with valid held. Dropping valid before accept is allowed and causes no effect.
- Fairness: under continuous requests from both sides, grants strictly alternate.

Test Plan:
- Req0 add a=3, b=5 (ALU model: done 4 cycles after sel) -> single alu_sel pulse with alu_op=0001; rsp_valid0 pulse; rsp_result=08h; err=0; rsp_valid1 stays 0.
- Both valid in the same cycle (req0 mul 3*4, req1 div 9/2) -> req0 served first, result 0Ch; then req1, result 04h. Two responses in order; never two readys high together.
- Req1 div a=7, b=0 -> rsp_valid1 one cycle after accept, err=1, result 00h; alu_sel never asserted.
- Req0 op=0011 -> err=1, result 00h; no alu_sel pulse.
- TIMEOUT=16, ALU model never raises done -> rsp_valid0 after 16 WAIT cycles with result FFh, err=1; next request then served normally.
- Assert rst during WAIT, and separately drive alu_done stale-high in the first WAIT cycle:
  - rst -> all outputs 0 immediately and no response issued; after release, a fresh req0 add 1+1 returns 02h.
  - Stale done -> ignored; the real done two cycles later is the one captured.
